// File: rtl/regfile_access_ctrl_if.sv
// Bundle of the read-request, operand-response, writeback and register-file
// port signals seen by the register file access controller.
interface regfile_access_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_src_a;
    logic [ADDR_W-1:0] req_src_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_op_a;
    logic [DATA_W-1:0] rsp_op_b;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rf_ad_a;
    logic [ADDR_W-1:0] rf_ad_b;
    logic [ADDR_W-1:0] rf_ad_c;
    logic              rf_wr_acc;
    logic [DATA_W-1:0] rf_data_wr;
    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;
    logic              rf_wr_busy;

    // Controller side.
    modport slave (
        input  req_valid, req_src_a, req_src_b, rsp_ready,
        input  wb_valid, wb_addr, wb_data,
        input  rf_data_a, rf_data_b, rf_wr_busy,
        output req_ready, rsp_valid, rsp_op_a, rsp_op_b, wb_ready,
        output rf_ad_a, rf_ad_b, rf_ad_c, rf_wr_acc, rf_data_wr
    );

    // Decode / execute / register file side.
    modport master (
        output req_valid, req_src_a, req_src_b, rsp_ready,
        output wb_valid, wb_addr, wb_data,
        output rf_data_a, rf_data_b, rf_wr_busy,
        input  req_ready, rsp_valid, rsp_op_a, rsp_op_b, wb_ready,
        input  rf_ad_a, rf_ad_b, rf_ad_c, rf_wr_acc, rf_data_wr
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: three-state operand read FSM with
// forwarding from a writeback FIFO that drains one entry per cycle.
module regfile_access_ctrl #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int WB_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_access_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rf_ad_a_q, rf_ad_a_d, rf_ad_b_q, rf_ad_b_d;
    logic [DATA_W-1:0] rsp_op_a_q, rsp_op_a_d, rsp_op_b_q, rsp_op_b_d;
    wb_entry_t         fifo_q [WB_DEPTH];
    wb_entry_t         fifo_d [WB_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              req_fire, wb_push, wb_pop, fifo_nonempty;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic [PTR_W-1:0]  fwd_slot;
    wb_entry_t         head;

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Read FSM next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_fire) state_d = READ;
            READ:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read FSM outputs; ready is suppressed while reset is held.
    always_comb begin
        bus.req_ready = (state_q == IDLE) && !rst;
        bus.rsp_valid = (state_q == RESP);
    end

    assign req_fire = bus.req_valid && bus.req_ready;

    // Forwarding: walk valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a    = bus.rf_data_a;
        fwd_b    = bus.rf_data_b;
        fwd_slot = rd_ptr_q;
        for (int i = 0; i < WB_DEPTH; i++) begin
            fwd_slot = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (fifo_q[fwd_slot].addr == rf_ad_a_q) fwd_a = fifo_q[fwd_slot].data;
                if (fifo_q[fwd_slot].addr == rf_ad_b_q) fwd_b = fifo_q[fwd_slot].data;
            end
        end
    end

    // Read datapath: latch addresses on accept, capture operands in READ.
    always_comb begin
        rf_ad_a_d  = rf_ad_a_q;
        rf_ad_b_d  = rf_ad_b_q;
        rsp_op_a_d = rsp_op_a_q;
        rsp_op_b_d = rsp_op_b_q;
        if (req_fire) begin
            rf_ad_a_d = bus.req_src_a;
            rf_ad_b_d = bus.req_src_b;
        end
        if (state_q == READ) begin
            rsp_op_a_d = fwd_a;
            rsp_op_b_d = fwd_b;
        end
    end

    // Read datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_ad_a_q  <= '0;
            rf_ad_b_q  <= '0;
            rsp_op_a_q <= '0;
            rsp_op_b_q <= '0;
        end else begin
            rf_ad_a_q  <= rf_ad_a_d;
            rf_ad_b_q  <= rf_ad_b_d;
            rsp_op_a_q <= rsp_op_a_d;
            rsp_op_b_q <= rsp_op_b_d;
        end
    end

    assign bus.rf_ad_a  = rf_ad_a_q;
    assign bus.rf_ad_b  = rf_ad_b_q;
    assign bus.rsp_op_a = rsp_op_a_q;
    assign bus.rsp_op_b = rsp_op_b_q;

    // Writeback FIFO handshake and write-port drive from the head entry.
    always_comb begin
        head           = fifo_q[rd_ptr_q];
        fifo_nonempty  = (count_q != '0) && !rst;
        bus.wb_ready   = (count_q < CNT_W'(WB_DEPTH)) && !rst;
        wb_push        = bus.wb_valid && bus.wb_ready;
        wb_pop         = fifo_nonempty && !bus.rf_wr_busy;
        bus.rf_wr_acc  = wb_pop;
        bus.rf_ad_c    = fifo_nonempty ? head.addr : '0;
        bus.rf_data_wr = fifo_nonempty ? head.data : '0;
    end

    // Writeback FIFO next state: store on push, advance pointers, track count.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wb_push) begin
            fifo_d[wr_ptr_q] = '{addr: bus.wb_addr, data: bus.wb_data};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (wb_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wb_push, wb_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Writeback FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Writeback FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_q gates every read of it.
        fifo_q <= fifo_d;
    end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl. The reference model tracks the
// architectural register view (regfile plus every accepted writeback) and the
// queue of writebacks still to be committed.
module tb_regfile_access_ctrl;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } ops_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

    regfile_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Register file model: combinational reads, write at the clock edge.
    logic [DATA_W-1:0] rf_mem [32];
    logic              rf_init;
    logic              do_wr;
    logic [ADDR_W-1:0] wr_a;
    logic [DATA_W-1:0] wr_d;

    assign ifc.rf_data_a = rf_mem[ifc.rf_ad_a];
    assign ifc.rf_data_b = rf_mem[ifc.rf_ad_b];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= {32'h1000_0000 | 32'(i), 32'(i * 3)};
        end else if (do_wr) begin
            rf_mem[wr_a] <= wr_d;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state.
    logic [DATA_W-1:0] arch [32];
    wb_t               commit_q [$];
    ops_t              exp_q [$];
    int                cyc = 0;
    int                acc_cyc = 0;
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic [DATA_W-1:0] prev_a, prev_b;
    logic              after_rst = 1'b0;

    // Monitor: samples mid-cycle, i.e. the values the next rising edge will see.
    initial begin
        wb_t  e;
        ops_t o;
        do_wr = 1'b0;
        wr_a  = '0;
        wr_d  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            do_wr = 1'b0;
            if (rst) begin
                check("rst_req_ready", 64'(ifc.req_ready), 64'(0));
                check("rst_wb_ready",  64'(ifc.wb_ready),  64'(0));
                check("rst_rf_wr_acc", 64'(ifc.rf_wr_acc), 64'(0));
                arch = rf_mem;
                commit_q.delete();
                exp_q.delete();
                prev_valid = 1'b0;
                prev_ready = 1'b0;
                after_rst  = 1'b1;
            end else begin
                if (after_rst) begin
                    check("post_rst_rsp_valid", 64'(ifc.rsp_valid), 64'(0));
                    check("post_rst_op_a", ifc.rsp_op_a, 64'(0));
                    check("post_rst_op_b", ifc.rsp_op_b, 64'(0));
                    check("post_rst_ad_a", 64'(ifc.rf_ad_a), 64'(0));
                    check("post_rst_ad_b", 64'(ifc.rf_ad_b), 64'(0));
                    after_rst = 1'b0;
                end

                // Write port.
                check("rf_wr_acc", 64'(ifc.rf_wr_acc), 64'(commit_q.size() != 0 && !ifc.rf_wr_busy));
                if (commit_q.size() != 0) begin
                    check("rf_ad_c", 64'(ifc.rf_ad_c), 64'(commit_q[0].addr));
                    check("rf_data_wr", ifc.rf_data_wr, commit_q[0].data);
                end else begin
                    check("rf_ad_c_empty", 64'(ifc.rf_ad_c), 64'(0));
                    check("rf_data_wr_empty", ifc.rf_data_wr, 64'(0));
                end
                check("wb_ready", 64'(ifc.wb_ready), 64'(commit_q.size() < WB_DEPTH));
                if (ifc.rf_wr_acc) begin
                    do_wr = 1'b1;
                    wr_a  = ifc.rf_ad_c;
                    wr_d  = ifc.rf_data_wr;
                    if (commit_q.size() != 0) e = commit_q.pop_front();
                end

                // Read side.
                check("req_ready", 64'(ifc.req_ready), 64'(exp_q.size() == 0));
                if (ifc.rsp_valid && !prev_valid)
                    check("rsp_latency", 64'(cyc - acc_cyc), 64'(2));
                if (prev_valid && !prev_ready) begin
                    check("rsp_hold_valid", 64'(ifc.rsp_valid), 64'(1));
                    check("rsp_hold_op_a", ifc.rsp_op_a, prev_a);
                    check("rsp_hold_op_b", ifc.rsp_op_b, prev_b);
                end
                prev_valid = ifc.rsp_valid;
                prev_ready = ifc.rsp_ready;
                prev_a     = ifc.rsp_op_a;
                prev_b     = ifc.rsp_op_b;

                if (ifc.wb_valid && ifc.wb_ready) begin
                    arch[ifc.wb_addr] = ifc.wb_data;
                    commit_q.push_back('{addr: ifc.wb_addr, data: ifc.wb_data});
                end
                if (ifc.rsp_valid && ifc.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(1), 64'(0));
                    end else begin
                        o = exp_q.pop_front();
                        check("rsp_op_a", ifc.rsp_op_a, o.a);
                        check("rsp_op_b", ifc.rsp_op_b, o.b);
                    end
                end
                if (ifc.req_valid && ifc.req_ready) begin
                    exp_q.push_back('{a: arch[ifc.req_src_a], b: arch[ifc.req_src_b]});
                    acc_cyc = cyc;
                end
            end
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        ifc.wb_valid = 1'b1;
        ifc.wb_addr  = a;
        ifc.wb_data  = d;
        while (!ifc.wb_ready && n < 50) begin step(); n++; end
        check("wb_accept_bound", 64'(n < 50), 64'(1));
        step();
        ifc.wb_valid = 1'b0;
    endtask

    task automatic do_req(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        int n = 0;
        ifc.req_valid = 1'b1;
        ifc.req_src_a = a;
        ifc.req_src_b = b;
        while (!ifc.req_ready && n < 50) begin step(); n++; end
        check("req_accept_bound", 64'(n < 50), 64'(1));
        step();
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ifc.rsp_valid && n < 50) begin step(); n++; end
        check("rsp_valid_bound", 64'(n < 50), 64'(1));
    endtask

    task automatic take_rsp(input int hold);
        ifc.rsp_ready = 1'b0;
        wait_valid();
        repeat (hold) step();
        ifc.rsp_ready = 1'b1;
        step();
        ifc.rsp_ready = 1'b0;
    endtask

    initial begin
        ifc.req_valid  = 1'b0;
        ifc.req_src_a  = '0;
        ifc.req_src_b  = '0;
        ifc.rsp_ready  = 1'b0;
        ifc.wb_valid   = 1'b0;
        ifc.wb_addr    = '0;
        ifc.wb_data    = '0;
        ifc.rf_wr_busy = 1'b0;
        rf_init        = 1'b1;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rf_init = 1'b0;
        rst     = 1'b0;
        step();

        // Single writeback drains the next cycle, then read it back.
        do_wb(5'd1, 64'd1);
        repeat (2) step();
        do_req(5'd1, 5'd0);
        take_rsp(3);

        // Two writebacks to the same register held by a busy write port.
        ifc.rf_wr_busy = 1'b1;
        do_wb(5'd3, 64'hA);
        do_wb(5'd3, 64'hB);
        do_req(5'd3, 5'd3);
        take_rsp(0);
        ifc.rf_wr_busy = 1'b0;
        repeat (3) step();

        // Fill the FIFO, stall a fifth writeback, then release the port.
        ifc.rf_wr_busy = 1'b1;
        for (int i = 0; i < WB_DEPTH; i++) do_wb(5'(10 + i), 64'(100 + i));
        ifc.wb_valid = 1'b1;
        ifc.wb_addr  = 5'd14;
        ifc.wb_data  = 64'd104;
        repeat (3) step();
        ifc.rf_wr_busy = 1'b0;
        begin
            int n = 0;
            while (!ifc.wb_ready && n < 50) begin step(); n++; end
            check("stall_release_bound", 64'(n < 50), 64'(1));
        end
        step();
        ifc.wb_valid = 1'b0;
        repeat (6) step();

        // Writeback accepted during READ is younger than the read.
        do_req(5'd5, 5'd6);
        ifc.wb_valid = 1'b1;
        ifc.wb_addr  = 5'd5;
        ifc.wb_data  = 64'hDEAD_BEEF;
        step();
        ifc.wb_valid = 1'b0;
        take_rsp(1);
        repeat (3) step();

        // Reset during RESP with two pending entries discards them.
        ifc.rf_wr_busy = 1'b1;
        do_wb(5'd7, 64'h77);
        do_wb(5'd8, 64'h88);
        do_req(5'd7, 5'd8);
        wait_valid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifc.rf_wr_busy = 1'b0;
        repeat (3) step();
        do_req(5'd7, 5'd8);
        take_rsp(0);

        // Randomized traffic over a small address window to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            ifc.req_valid  = ($urandom_range(0, 1) == 1);
            ifc.req_src_a  = 5'($urandom_range(0, 7));
            ifc.req_src_b  = 5'($urandom_range(0, 7));
            ifc.rsp_ready  = ($urandom_range(0, 2) != 0);
            ifc.wb_valid   = ($urandom_range(0, 1) == 1);
            ifc.wb_addr    = 5'($urandom_range(0, 7));
            ifc.wb_data    = {$urandom, $urandom};
            ifc.rf_wr_busy = ($urandom_range(0, 3) == 0);
            rst            = ($urandom_range(0, 499) == 0);
            step();
        end
        rst           = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.wb_valid  = 1'b0;
        ifc.rsp_ready = 1'b1;
        ifc.rf_wr_busy = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
